// File: rtl/serial_pkg.sv
// Shared types and helpers for the parametrised serial receiver/transmitter family.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_sync.sv
// Flop-chain synchroniser for an asynchronous input; resets to the line idle level (1).
module serial_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised oversampling serial receiver with parity/framing checks and an
// armed idle timeout that fires once after each frame.
module serial_rx_param
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned OVERSAMPLE   = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned TIMEOUT_BITS = 5,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 timeout,
  output logic                 busy
);

  localparam int unsigned H     = OVERSAMPLE / 2;
  localparam int unsigned CNT_W = cnt_width(OVERSAMPLE - 1);
  localparam int unsigned IDX_W = cnt_width(DATA_BITS - 1);
  localparam int unsigned IDL_W = cnt_width(TIMEOUT_BITS);

  rx_state_t            r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDL_W-1:0]     r_idle;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_par_err, r_stop_bit, r_pend, r_armed;
  logic                 r_valid, r_parity_err, r_frame_err, r_timeout, r_busy;

  logic w_rx_s, w_tick, w_half, w_to_hit;
  logic w_cnt_clr, w_shift_en, w_par_en, w_stop_en, w_start_ok;

  serial_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  assign w_tick   = (r_cnt == CNT_W'(OVERSAMPLE - 1));
  assign w_half   = (r_cnt == CNT_W'(H - 1));
  assign w_to_hit = r_armed && (r_idle == IDL_W'(TIMEOUT_BITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_stop_en    = 1'b0;
    w_start_ok   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        // Mid start bit: a line already back high is a glitch, not a frame.
        if (w_half) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DATA;
            w_start_ok   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_idx == IDX_W'(DATA_BITS - 1))
            w_state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_par_en     = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_stop_en    = 1'b1;
          w_state_next = w_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_stop_bit <= 1'b1;
      r_pend     <= 1'b0;
    end else begin
      if (w_cnt_clr || w_tick) r_cnt <= '0;
      else                     r_cnt <= r_cnt + CNT_W'(1);

      if (r_state != S_DATA) r_idx <= '0;
      else if (w_shift_en)   r_idx <= r_idx + IDX_W'(1);

      if (w_shift_en) r_shift[r_idx] <= w_rx_s;
      if (w_par_en)   r_par_err <= (((^r_shift) ^ w_rx_s) != (PARITY == PAR_ODD));
      if (w_stop_en)  r_stop_bit <= w_rx_s;
      r_pend <= w_stop_en;
    end
  end

  // Result registers update together with the one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= r_pend;
      r_busy  <= (w_state_next != S_IDLE);
      if (r_pend) begin
        r_data_out   <= r_shift;
        r_parity_err <= r_par_err;
        r_frame_err  <= ~r_stop_bit;
      end
    end
  end

  // Idle bit-period counter and the armed timeout; a confirmed start wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle    <= '0;
      r_armed   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_rx_s)
        r_idle <= '0;
      else if ((r_state == S_IDLE) && w_tick && (r_idle != IDL_W'(TIMEOUT_BITS)))
        r_idle <= r_idle + IDL_W'(1);

      if (r_pend)                       r_armed <= 1'b1;
      else if (w_to_hit && !w_start_ok) r_armed <= 1'b0;

      if (w_start_ok)    r_timeout <= 1'b0;
      else if (w_to_hit) r_timeout <= 1'b1;
    end
  end

  assign data_out   = r_data_out;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign timeout    = r_timeout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_rx_param.sv
// Scoreboard bench for serial_rx_param: an 8N1 instance and an even-parity instance.
module tb_serial_rx_param;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] do_a, do_b;
  logic va, pe_a, fe_a, to_a, busy_a;
  logic vb, pe_b, fe_b, to_b, busy_b;
  logic va_prev = 1'b0;
  logic vb_prev = 1'b0;

  sb_item_t q_a[$];
  sb_item_t q_b[$];
  sb_item_t it_a, it_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_param dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data_out(do_a), .valid(va),
    .parity_err(pe_a), .frame_err(fe_a), .timeout(to_a), .busy(busy_a)
  );

  serial_rx_param #(.PARITY(1)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data_out(do_b), .valid(vb),
    .parity_err(pe_b), .frame_err(fe_b), .timeout(to_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (va === 1'b1) begin
      chk("a_valid_single_cycle", int'(va_prev), 0);
      if (q_a.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        it_a = q_a.pop_front();
        chk("a_data", int'(do_a), int'(it_a.data));
        chk("a_parity_err", int'(pe_a), int'(it_a.perr));
        chk("a_frame_err", int'(fe_a), int'(it_a.ferr));
        chk("a_valid_cycle", cyc, it_a.cyc);
      end
    end
    va_prev <= va;
  end

  always @(negedge clk) begin
    if (vb === 1'b1) begin
      chk("b_valid_single_cycle", int'(vb_prev), 0);
      if (q_b.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        it_b = q_b.pop_front();
        chk("b_data", int'(do_b), int'(it_b.data));
        chk("b_parity_err", int'(pe_b), int'(it_b.perr));
        chk("b_frame_err", int'(fe_b), int'(it_b.ferr));
        chk("b_valid_cycle", cyc, it_b.cyc);
      end
    end
    vb_prev <= vb;
  end

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at the next falling clock edge; line is left at the stop level.
  task automatic send(input int sel, input logic [7:0] d, input bit use_par, input logic pbit,
                      input logic stop, input bit push, input logic e_perr);
    sb_item_t item;
    int p;
    @(negedge clk);
    p = use_par ? 1 : 0;
    if (push) begin
      item.data = d;
      item.perr = e_perr;
      item.ferr = ~stop;
      item.cyc  = cyc + 6 + (8 + p + 1) * 4;
      if (sel == 0) q_a.push_back(item);
      else          q_b.push_back(item);
    end
    set_rx(sel, 1'b0);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      idle(4);
    end
    if (use_par) begin
      set_rx(sel, pbit);
      idle(4);
    end
    set_rx(sel, stop);
    idle(4);
  endtask

  initial begin
    idle(3);
    chk("rst_data_out", int'(do_a), 0);
    chk("rst_valid", int'(va), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_timeout", int'(to_a), 0);
    chk("rst_flags", int'({pe_a, fe_a}), 0);
    rst = 1'b0;

    idle(60);
    chk("no_timeout_without_frame", int'(to_a), 0);

    send(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(10);
    send(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);

    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);

    set_rx(0, 1'b0);
    idle(1);
    set_rx(0, 1'b1);
    idle(2);
    chk("false_start_busy_high", int'(busy_a), 1);
    idle(4);
    chk("false_start_busy_low", int'(busy_a), 0);
    idle(10);

    send(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    chk("break_busy", int'(busy_a), 1);
    set_rx(0, 1'b1);
    idle(10);
    chk("break_released", int'(busy_a), 0);
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(8);

    send(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(15);
    chk("timeout_not_early", int'(to_a), 0);
    idle(15);
    chk("timeout_set", int'(to_a), 1);
    idle(30);
    chk("timeout_held", int'(to_a), 1);
    fork
      send(0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        @(negedge clk);
        idle(3);
        chk("timeout_before_confirm", int'(to_a), 1);
        idle(3);
        chk("timeout_cleared_by_start", int'(to_a), 0);
      end
    join
    idle(40);

    fork
      send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        idle(18);
        chk("mid_frame_busy", int'(busy_a), 1);
        rst = 1'b1;
        #1;
        chk("reset_data_out", int'(do_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_outputs", int'({va, pe_a, fe_a, to_a}), 0);
        idle(2);
        rst = 1'b0;
      end
    join
    idle(30);
    chk("after_abort_idle", int'(busy_a), 0);
    send(0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
